// File: rtl/execute_pkg.sv
// Shared Execute-stage definitions: divider FSM states and timing constants.
package execute_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_CYCLES  = 16;
    localparam int DIV_LATENCY = 18;

endpackage

// File: rtl/seq_div16_if.sv
// Start/busy/done handshake between the Execute stage (master) and the divider (slave).
interface seq_div16_if #(parameter int WIDTH = 16);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   prem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   prem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;
    logic           fits_s;

    assign shifted_s = {prem[WIDTH-1:0], in_bit};
    assign diff_s    = shifted_s - {1'b0, divisor};
    // A set prem MSB would mean the shifted value exceeds any divisor, so it always fits.
    assign fits_s    = prem[WIDTH] | ~diff_s[WIDTH];

    // Keep the difference when the subtraction did not borrow, otherwise restore.
    always_comb begin
        prem_next = shifted_s;
        q_bit     = 1'b0;
        if (fits_s) begin
            prem_next = diff_s;
            q_bit     = 1'b1;
        end else begin
            prem_next = shifted_s;
            q_bit     = 1'b0;
        end
    end

endmodule

// File: rtl/seq_div16.sv
// Iterative restoring divider, one quotient bit per clock, signed (truncating) or unsigned.
module seq_div16
    import execute_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    seq_div16_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t       state_r, state_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic [WIDTH:0]   prem_r, prem_nxt_s;
    logic [WIDTH-1:0] wq_r, wq_nxt_s;
    logic [WIDTH-1:0] dvs_r, dvs_nxt_s;
    logic             sgn_r, sgn_nxt_s;
    logic             neg_dvd_r, neg_dvd_nxt_s;
    logic             neg_dvs_r, neg_dvs_nxt_s;
    logic [WIDTH-1:0] quo_r, quo_nxt_s;
    logic [WIDTH-1:0] rem_r, rem_nxt_s;
    logic             dbz_r, dbz_nxt_s;
    logic             ovf_r, ovf_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;

    logic             dvd_neg_s, dvs_neg_s;
    logic [WIDTH-1:0] dvd_abs_s, dvs_abs_s;
    logic [WIDTH:0]   step_prem_s;
    logic             step_bit_s;

    // abs(most-negative) wraps to itself, which is the correct unsigned magnitude.
    assign dvd_neg_s = bus.is_signed & bus.dividend[WIDTH-1];
    assign dvs_neg_s = bus.is_signed & bus.divisor[WIDTH-1];
    assign dvd_abs_s = dvd_neg_s ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    assign dvs_abs_s = dvs_neg_s ? (~bus.divisor + WIDTH'(1)) : bus.divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem_r),
        .in_bit    (wq_r[WIDTH-1]),
        .divisor   (dvs_r),
        .prem_next (step_prem_s),
        .q_bit     (step_bit_s)
    );

    // Next-state and next-datapath logic for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        prem_nxt_s    = prem_r;
        wq_nxt_s      = wq_r;
        dvs_nxt_s     = dvs_r;
        sgn_nxt_s     = sgn_r;
        neg_dvd_nxt_s = neg_dvd_r;
        neg_dvs_nxt_s = neg_dvs_r;
        quo_nxt_s     = quo_r;
        rem_nxt_s     = rem_r;
        dbz_nxt_s     = dbz_r;
        ovf_nxt_s     = ovf_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    sgn_nxt_s     = bus.is_signed;
                    neg_dvd_nxt_s = dvd_neg_s;
                    neg_dvs_nxt_s = dvs_neg_s;
                    wq_nxt_s      = dvd_abs_s;
                    dvs_nxt_s     = dvs_abs_s;
                    prem_nxt_s    = '0;
                    cnt_nxt_s     = '0;
                    if (bus.divisor == '0) begin
                        state_nxt_s = DONE;
                        quo_nxt_s   = '1;
                        rem_nxt_s   = bus.dividend;
                        dbz_nxt_s   = 1'b1;
                        ovf_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = CALC;
                        dbz_nxt_s   = 1'b0;
                        ovf_nxt_s   = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                prem_nxt_s = step_prem_s;
                wq_nxt_s   = {wq_r[WIDTH-2:0], step_bit_s};
                cnt_nxt_s  = cnt_r + CW'(1);
                if (cnt_r == CW'(DIV_CYCLES - 1)) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX: begin
                if (sgn_r & (neg_dvd_r ^ neg_dvs_r)) begin
                    quo_nxt_s = ~wq_r + WIDTH'(1);
                end else begin
                    quo_nxt_s = wq_r;
                end
                if (sgn_r & neg_dvd_r) begin
                    rem_nxt_s = ~prem_r[WIDTH-1:0] + WIDTH'(1);
                end else begin
                    rem_nxt_s = prem_r[WIDTH-1:0];
                end
                // Only most-negative / -1 yields magnitude quotient MSB-only from divisor magnitude 1.
                ovf_nxt_s   = sgn_r & neg_dvd_r & neg_dvs_r & (dvs_r == WIDTH'(1))
                              & (wq_r == {1'b1, {(WIDTH-1){1'b0}}});
                state_nxt_s = DONE;
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign busy_nxt_s = (state_nxt_s != IDLE);
    assign done_nxt_s = (state_nxt_s == DONE);

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            prem_r    <= '0;
            wq_r      <= '0;
            dvs_r     <= '0;
            sgn_r     <= 1'b0;
            neg_dvd_r <= 1'b0;
            neg_dvs_r <= 1'b0;
            quo_r     <= '0;
            rem_r     <= '0;
            dbz_r     <= 1'b0;
            ovf_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            prem_r    <= prem_nxt_s;
            wq_r      <= wq_nxt_s;
            dvs_r     <= dvs_nxt_s;
            sgn_r     <= sgn_nxt_s;
            neg_dvd_r <= neg_dvd_nxt_s;
            neg_dvs_r <= neg_dvs_nxt_s;
            quo_r     <= quo_nxt_s;
            rem_r     <= rem_nxt_s;
            dbz_r     <= dbz_nxt_s;
            ovf_r     <= ovf_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_seq_div16.sv
// Self-checking bench for seq_div16: vector table, handshake corner cases, randomized model checks.
module tb_seq_div16;
    import execute_pkg::*;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } res_t;

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    seq_div16_if #(.WIDTH(16)) bus ();

    seq_div16 #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, truncating toward zero in signed mode.
    function automatic res_t ref_div(input logic s, input logic [15:0] a, input logic [15:0] b);
        res_t res;
        int   sa, sb, qi, ri;
        res = '0;
        if (b == 16'd0) begin
            res.q  = 16'hFFFF;
            res.r  = a;
            res.dz = 1'b1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            qi = sa / sb;
            ri = sa % sb;
            res.q  = qi[15:0];
            res.r  = ri[15:0];
            res.ov = (sa == -32768) && (sb == -1);
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in the current (idle) cycle, waits for done, checks latency and the idle cycle after.
    task automatic do_div(input logic s, input logic [15:0] a, input logic [15:0] b, output res_t got);
        int lat;
        int exp_lat;
        exp_lat = (b == 16'd0) ? 1 : DIV_LATENCY;
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        step();
        bus.start     = 1'b0;
        bus.dividend  = 16'($urandom);
        bus.divisor   = 16'($urandom);
        bus.is_signed = 1'($urandom);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("busy_in_done", bus.busy, 1'b1);
        got = {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow};
        bus.start    = 1'b1;
        bus.dividend = 16'h0005;
        bus.divisor  = 16'h0005;
        step();
        bus.start = 1'b0;
        chk("idle_busy_after_done", bus.busy, 1'b0);
        chk("idle_done_after_done", bus.done, 1'b0);
        chk("quotient_held", bus.quotient, got.q);
        chk("remainder_held", bus.remainder, got.r);
    endtask

    vec_t tbl[11];
    res_t got;
    res_t exp_r;

    initial begin
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend = 16'h0000;
        bus.divisor = 16'h0000;
        tbl[0]  = '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 16'h00C8, 16'h000A, 16'h0014, 16'h0000, 1'b0, 1'b0};

        step();
        step();
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        chk("reset_quotient", bus.quotient, 16'h0000);
        chk("reset_remainder", bus.remainder, 16'h0000);
        chk("reset_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
        rst = 1'b0;
        step();

        // Cycle-accurate handshake for unsigned 100/7.
        bus.start = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend = 16'd100;
        bus.divisor = 16'd7;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            step();
            bus.start = 1'b0;
            chk($sformatf("busy_c%0d", cyc), bus.busy, (cyc <= 18) ? 1'b1 : 1'b0);
            chk($sformatf("done_c%0d", cyc), bus.done, (cyc == 18) ? 1'b1 : 1'b0);
            if (cyc == 18) begin
                chk("q_100_7", bus.quotient, 16'd14);
                chk("r_100_7", bus.remainder, 16'd2);
                chk("flags_100_7", {bus.div_by_zero, bus.overflow}, 2'b00);
            end
        end

        // Vector table.
        for (int i = 0; i < 11; i++) begin
            do_div(tbl[i].s, tbl[i].a, tbl[i].b, got);
            chk($sformatf("tbl%0d_q", i), got.q, tbl[i].q);
            chk($sformatf("tbl%0d_r", i), got.r, tbl[i].r);
            chk($sformatf("tbl%0d_dz", i), got.dz, tbl[i].dz);
            chk($sformatf("tbl%0d_ov", i), got.ov, tbl[i].ov);
        end

        // Start re-pulsed while busy must be ignored.
        bus.start = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend = 16'h00C8;
        bus.divisor = 16'h000A;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            step();
            bus.start = (cyc == 5) ? 1'b1 : 1'b0;
            if (cyc == 5) begin
                bus.dividend = 16'd5;
                bus.divisor = 16'd5;
            end
            if (cyc == 18) begin
                chk("ignore_done", bus.done, 1'b1);
                chk("ignore_q", bus.quotient, 16'd20);
                chk("ignore_r", bus.remainder, 16'd0);
            end
        end
        step();
        chk("ignore_idle", bus.busy, 1'b0);
        do_div(1'b0, 16'd9, 16'd3, got);
        chk("b2b_q", got.q, 16'd3);
        chk("b2b_r", got.r, 16'd0);

        // Reset asserted mid-operation aborts with no later done.
        bus.start = 1'b1;
        bus.is_signed = 1'b1;
        bus.dividend = 16'h1234;
        bus.divisor = 16'h0003;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step();
            bus.start = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_q", bus.quotient, 16'h0000);
        chk("abort_r", bus.remainder, 16'h0000);
        chk("abort_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
        begin
            int seen;
            seen = 0;
            for (int cyc = 0; cyc < 25; cyc++) begin
                step();
                if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
            end
            chk("abort_no_done", seen, 0);
        end
        do_div(1'b0, 16'd9, 16'd3, got);
        chk("post_abort_q", got.q, 16'd3);
        chk("post_abort_r", got.r, 16'd0);

        // Randomized operands against the arithmetic model.
        for (int n = 0; n < 150; n++) begin
            logic        s;
            logic [15:0] a, b;
            s = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0: b = 16'h0000;
                1: b = 16'hFFFF;
                2: a = 16'h8000;
                3: b = 16'($urandom_range(1, 15));
                default: ;
            endcase
            exp_r = ref_div(s, a, b);
            do_div(s, a, b, got);
            if (got !== exp_r) begin
                checks++;
                errors++;
                $display("FAIL rand%0d s=%0b %0h/%0h: got q=%0h r=%0h dz=%0b ov=%0b expected q=%0h r=%0h dz=%0b ov=%0b",
                         n, s, a, b, got.q, got.r, got.dz, got.ov, exp_r.q, exp_r.r, exp_r.dz, exp_r.ov);
            end else begin
                checks++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
